// File: rtl/dff_bank_pkg.sv
// Shared types and defaults for the arbitrated D flip-flop register bank.
// Contents: FSM state encoding, default parameter values and the bank reset value.
package dff_bank_pkg;

  // Write-handshake controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned NREG_DEF = 4;
  localparam int unsigned NREQ_DEF = 4;

  // Reset value of every bank bit, replicated to the data width at use
  localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Ports:
//   req  [NREQ]  pending request vector
//   ptr  [IW]    index holding highest priority this cycle
//   any          at least one request pending
//   idx  [IW]    first set bit at or above ptr, wrapping modulo NREQ
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest set bit to ptr wins
  always_comb begin
    any = |req;
    idx = '0;
    j   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = IW'((32'(ptr) + 32'(k)) % NREQ);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: NREQ write requesters share a bank of NREG registers.
// A round-robin pick selects one requester in IDLE; GRANT strobes its ready bit
// and captures its address/data; COMMIT writes the bank. One write per 3 cycles.
// Build option: define DFF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority
// (no rotating pointer); handshake, latency and bank are unchanged.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid[NREQ] per-requester write request
//   req_addr        packed addresses, requester i at [i*AW +: AW]
//   req_data        packed data, requester i at [i*DW +: DW]
//   req_ready[NREQ] registered one-hot accept strobe (high during GRANT)
//   rd_addr/rd_data combinational read port
//   grant_id        current/last granted requester (registered)
//   busy            high in GRANT and COMMIT (registered)
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  parameter  int unsigned DW   = DW_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG),
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  state_e         state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic           commit_c;
  logic [DW-1:0]  bank_q [NREG];

  logic [AW-1:0]  addr_arr [NREQ];
  logic [DW-1:0]  data_arr [NREQ];
  logic           pick_any;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  ptr_c;

  // Unpack the requester buses for indexed selection by grant_q
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*AW +: AW];
    assign data_arr[g] = req_data[g*DW +: DW];
  end

`ifdef DFF_ARB_FIXED_PRIO_EN
  // Fixed priority: scan always starts at requester 0
  assign ptr_c = '0;
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer advances past the winner only when its write commits
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == COMMIT) begin
      rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign ptr_c = rr_ptr_q;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_c),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   state_d = req_valid[grant_q] ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; ready is set on entry so it is high during GRANT
  always_comb begin
    ready_d   = '0;
    busy_d    = (state_d != IDLE);
    grant_d   = grant_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    commit_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          ready_d = NREQ'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (req_valid[grant_q]) begin
          wr_addr_d = addr_arr[grant_q];
          wr_data_d = data_arr[grant_q];
        end
      end
      COMMIT:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // Register bank; reset wins over a pending commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) bank_q[i] <= {DW{RST_VAL}};
    end else if (commit_c) begin
      bank_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign rd_data   = bank_q[rd_addr];
  assign req_ready = ready_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (default parameters NREQ=4, DW=8, NREG=4).
// Honours DFF_ARB_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_dff_bank_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 2;
  localparam int unsigned IW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       rd_addr;
  logic [DW-1:0]       rd_data;
  logic [IW-1:0]       grant_id;
  logic                busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dff_bank_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int a, input int d);
    req_addr[r*AW +: AW] = AW'(a);
    req_data[r*DW +: DW] = DW'(d);
  endtask

  task automatic rd_chk(input string tag, input int a, input int e);
    rd_addr = AW'(a);
    #1;
    chk(tag, 32'(rd_data), 32'(e));
  endtask

  initial begin
    logic [IW-1:0] exp_seq [5];
    int            exp_bank [4];
    int            n;
    int            last;

    for (int i = 0; i < 5; i++) begin
`ifdef DFF_ARB_FIXED_PRIO_EN
      exp_seq[i] = '0;
`else
      exp_seq[i] = IW'(i % 4);
`endif
    end
    for (int i = 0; i < 4; i++) begin
`ifdef DFF_ARB_FIXED_PRIO_EN
      exp_bank[i] = (i == 0) ? 32'hC0 : 0;
`else
      exp_bank[i] = 32'hC0 | i;
`endif
    end

    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rd_addr = '0;

    // Reset state
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    for (int a = 0; a < 4; a++) rd_chk("rst_bank", a, 0);
    rst = 1'b0;
    tick();

    // Round-robin with all requesters continuously valid
    for (int i = 0; i < 4; i++) set_req(i, i, 32'hC0 | i);
    req_valid = 4'b1111;
    n = 0;
    last = 0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (req_ready != '0) begin
        if (n < 5) begin
          chk("rr_ready", 32'(req_ready), 32'(1) << exp_seq[n]);
          chk("rr_grant", 32'(grant_id), 32'(exp_seq[n]));
          if (n > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
        end
        last = cyc;
        n++;
      end
    end
    req_valid = '0;
    chk("rr_count", 32'(n), 32'd5);
    for (int a = 0; a < 4; a++) rd_chk("rr_bank", a, exp_bank[a]);

    // Single write by requester 2
    set_req(2, 1, 32'hA5);
    req_valid = 4'b0100;
    chk("sw_ready_early", 32'(req_ready), 32'h0);
    tick();
    chk("sw_ready", 32'(req_ready), 32'h4);
    chk("sw_grant", 32'(grant_id), 32'd2);
    chk("sw_busy_grant", 32'(busy), 32'h1);
    tick();
    req_valid = '0;
    chk("sw_ready_width", 32'(req_ready), 32'h0);
    chk("sw_busy_commit", 32'(busy), 32'h1);
    rd_chk("sw_old", 1, 32'(exp_bank[1]));
    tick();
    rd_chk("sw_new", 1, 32'hA5);
    chk("sw_busy_idle", 32'(busy), 32'h0);

    // Requester 3 alone, then wrap-around to requester 0 with a read/write collision
    set_req(3, 3, 32'h5A);
    req_valid = 4'b1000;
    tick();
    chk("wr3_grant", 32'(grant_id), 32'd3);
    tick();
    req_valid = '0;
    tick();
    rd_chk("wr3_bank", 3, 32'h5A);
    set_req(0, 2, 32'h77);
    req_valid = 4'b1001;
    tick();
    chk("wrap_grant", 32'(grant_id), 32'd0);
    chk("wrap_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    rd_chk("coll_old", 2, 32'(exp_bank[2]));
    tick();
    rd_chk("coll_new", 2, 32'h77);

    // Withdrawal in GRANT keeps the pointer; requester 1 wins again
    set_req(1, 0, 32'h99);
    set_req(2, 3, 32'h11);
    req_valid = 4'b0110;
    tick();
    chk("wd_grant", 32'(grant_id), 32'd1);
    req_valid = 4'b0100;
    tick();
    chk("wd_busy", 32'(busy), 32'h0);
    chk("wd_ready", 32'(req_ready), 32'h0);
    rd_chk("wd_bank", 0, 32'(exp_bank[0]));
    req_valid = 4'b0110;
    tick();
    chk("wd_regrant", 32'(grant_id), 32'd1);
    tick();
    req_valid = '0;
    tick();
    rd_chk("wd_commit", 0, 32'h99);
    rd_chk("wd_other", 3, 32'h5A);

    // Reset asserted during COMMIT drops the captured write
    set_req(2, 1, 32'h3C);
    req_valid = 4'b0100;
    tick();
    tick();
    req_valid = '0;
    chk("mr_in_commit", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ready", 32'(req_ready), 32'h0);
    chk("mr_grant", 32'(grant_id), 32'h0);
    for (int a = 0; a < 4; a++) rd_chk("mr_bank", a, 0);
    tick();
    rd_chk("mr_target", 1, 0);
    chk("mr_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Shares a small bank of reset-able D flip-flop registers between NREQ write requesters.
- A round-robin arbiter picks one pending requester.
- A 3-state controller sequences the handshake and the single-cycle register write.
- The bank is read combinationally through one read port.
- Sits between multiple producer blocks and the shared configuration/state register bank.

Parameters:
NREQ, 4, number of write requesters (2..8)
DW, 8, register data width
NREG, 4, number of registers in the bank (power of 2)
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed data, requester i at [i*DW +: DW]
req_ready  output  NREQ  one-hot accept strobe, registered
rd_addr  input  AW  read address
rd_data  output  DW  bank[rd_addr], combinational
grant_id  output  $clog2(NREQ)  index of current/last granted requester
busy  output  1  high in GRANT and COMMIT

Behaviour:
- Reset (rst=1 at a clock edge): all bank registers=0, state=IDLE, rr_ptr=0, req_ready=0, grant_id=0, busy=0. Reset overrides any operation in flight; a write captured but not yet committed is dropped.
- State machine:
  - IDLE: if any req_valid, winner = first set bit scanning from rr_ptr upward, modulo NREQ. Next edge: grant_id<=winner, state<=GRANT. If no req_valid, stay in IDLE.
  - GRANT: req_ready[grant_id]=1; all other ready bits 0.
    - If req_valid[grant_id]=1 at the edge: capture req_addr/req_data of grant_id into wr_addr/wr_data, state<=COMMIT.
    - If req_valid[grant_id]=0 (requester withdrew): no capture, state<=IDLE, rr_ptr unchanged.
  - COMMIT: at the edge, bank[wr_addr]<=wr_data, rr_ptr<=(grant_id+1) mod NREQ, state<=IDLE.
- Requester contract: hold req_valid, addr and data stable from assertion until the cycle in which req_ready is seen high.
- Timing:
  - Minimum 3 cycles per accepted write; max throughput is 1 write per 3 cycles.
  - rd_data reflects the new value the cycle after the COMMIT edge.
  - Worst-case wait for a continuously requesting master is (NREQ-1)*3 cycles after its request is visible in IDLE.
- Requests arriving during GRANT/COMMIT are not considered until the next IDLE. No queueing.
- Wrap-around: rr_ptr=NREQ-1 with winner NREQ-1 gives next rr_ptr=0.
- Simultaneous read/write same address: rd_data shows the old value during COMMIT, the new value afterwards.
- rd_data is valid during reset, reading 0 after the reset edge.

Optional Feature:
DFF_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index valid requester always wins. rr_ptr is not implemented, and a continuously requesting low-index master may starve the others.
- Undefined (default): round-robin as specified above.
- Handshake, latency and the bank are identical in both builds.

Decomposition:
- Package dff_bank_pkg holds:
  - state enum: IDLE=2'd0, GRANT=2'd1, COMMIT=2'd2
  - default widths: DW_DEF=8, NREG_DEF=4, NREQ_DEF=4
  - constant RST_VAL='0
- One sub-module: rr_pick.
  - Combinational rotating-priority encoder with inputs req[NREQ], ptr and outputs any, idx.
  - Under DFF_ARB_FIXED_PRIO_EN, ptr is tied to 0.
- Bank and FSM stay in the top module.

Test Plan:
- Reset: drive bank writes, then rst=1 for 1 cycle -> every rd_addr 0..3 reads 0, req_ready=0, busy=0, grant_id=0.
- Single write: req_valid[2]=1, addr=1, data=8'hA5 -> req_ready[2] high exactly 2 cycles after request, 1 cycle wide; rd_data at addr 1 = 8'hA5 from the 4th cycle onward.
- Round-robin fairness: all four requesters valid continuously, each writing its own index to addr=i -> grant_id sequence 0,1,2,3,0; each req_ready pulse 3 cycles apart. With DFF_ARB_FIXED_PRIO_EN the sequence is 0,0,0...
- Withdrawal: req_valid[1] dropped in GRANT -> no write, bank unchanged, return to IDLE, rr_ptr unchanged, so requester 1 wins again when it re-asserts.
- Reset mid-operation: rst asserted in COMMIT with wr_data=8'h3C -> target register reads 0, state IDLE next cycle.
- Wrap-around and collision: last grant to 3, then req_valid=4'b1001 -> requester 0 wins. Read addr equal to the write addr during COMMIT -> old value, then new value.
